// File: rtl/gat_agg_pkg.sv
// Shared types and helpers for the GAT aggregation stage (softmax -> aggregator).
package gat_agg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } agg_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Accumulator width that absorbs every product of a full neighbour sweep.
  function automatic int acc_width(input int feat_w, input int data_w, input int nodes);
    return feat_w + data_w + clog2(nodes);
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/agg_mac_lane.sv
// One feature lane of the aggregator: signed feature x unsigned alpha, accumulated.
// Build option: AGG_RELU_EN clamps the lane output at zero (accumulator untouched).
module agg_mac_lane #(
  parameter int FEAT_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [FEAT_WIDTH-1:0] feat,
  input  logic [DATA_WIDTH-1:0] alpha,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  localparam int PROD_W = FEAT_WIDTH + DATA_WIDTH;

  logic signed [FEAT_WIDTH-1:0] feat_s;
  logic signed [PROD_W-1:0]     feat_x;
  logic signed [PROD_W-1:0]     alpha_x;
  logic signed [PROD_W-1:0]     prod_p0;
  logic signed [ACC_WIDTH-1:0]  acc_p1;

`ifdef AGG_RELU_EN
  function automatic logic signed [ACC_WIDTH-1:0] relu(input logic signed [ACC_WIDTH-1:0] v);
    return v[ACC_WIDTH-1] ? '0 : v;
  endfunction
`endif

  // p0: product; alpha is zero-extended so it stays non-negative in signed math
  assign feat_s  = $signed(feat);
  assign feat_x  = PROD_W'(feat_s);
  assign alpha_x = PROD_W'({1'b0, alpha});
  assign prod_p0 = feat_x * alpha_x;

  // p1: accumulator
  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc_p1 <= '0;
    end else if (clr) begin
      acc_p1 <= '0;
    end else if (en) begin
      acc_p1 <= acc_p1 + ACC_WIDTH'(prod_p0);
    end
  end

`ifdef AGG_RELU_EN
  assign acc_o = relu(acc_p1);
`else
  assign acc_o = acc_p1;
`endif

endmodule

// File: rtl/aggregator.sv
// GAT aggregator: h'[k] = sum_j alpha_j * Wh_j[k], one neighbour beat per transfer.
// Build option: AGG_RELU_EN applies ReLU to every output lane.
module aggregator
  import gat_agg_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int NUM_OF_NODES = 5,
  parameter  int FEAT_WIDTH   = 8,
  parameter  int NUM_OF_FEATS = 4,
  localparam int ACC_WIDTH    = acc_width(FEAT_WIDTH, DATA_WIDTH, NUM_OF_NODES)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               alpha_valid_i,
  output logic                               alpha_ready_o,
  input  logic [NUM_OF_NODES*DATA_WIDTH-1:0] alpha_i,
  input  logic                               feat_valid_i,
  output logic                               feat_ready_o,
  input  logic [NUM_OF_FEATS*FEAT_WIDTH-1:0] feat_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [NUM_OF_FEATS*ACC_WIDTH-1:0]  h_o
);

  localparam int               CNT_W    = (NUM_OF_NODES > 1) ? clog2(NUM_OF_NODES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OF_NODES - 1);

  agg_state_e            state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] alpha_q [NUM_OF_NODES];
  logic [DATA_WIDTH-1:0] alpha_sel;
  logic                  alpha_xfer, feat_xfer, out_xfer, last_beat;

  assign alpha_xfer = alpha_valid_i & alpha_ready_o;
  assign feat_xfer  = feat_valid_i & feat_ready_o;
  assign out_xfer   = out_valid_o & out_ready_i;
  assign last_beat  = (cnt == LAST_CNT);
  assign alpha_sel  = alpha_q[cnt];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (alpha_xfer) state_nxt = ACCUM;
      ACCUM:   if (feat_xfer && last_beat) state_nxt = DONE;
      DONE:    if (out_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next state, held low in reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      alpha_ready_o <= 1'b0;
      feat_ready_o  <= 1'b0;
      out_valid_o   <= 1'b0;
    end else begin
      state         <= state_nxt;
      alpha_ready_o <= (state_nxt == IDLE);
      feat_ready_o  <= (state_nxt == ACCUM);
      out_valid_o   <= (state_nxt == DONE);
      if (alpha_xfer || (feat_xfer && last_beat)) begin
        cnt <= '0;
      end else if (feat_xfer) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alpha_xfer) begin
      for (int j = 0; j < NUM_OF_NODES; j++) begin
        alpha_q[j] <= alpha_i[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  for (genvar k = 0; k < NUM_OF_FEATS; k++) begin : g_lane
    agg_mac_lane #(
      .FEAT_WIDTH(FEAT_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (alpha_xfer),
      .en   (feat_xfer),
      .feat (feat_i[lane_lsb(k, FEAT_WIDTH) +: FEAT_WIDTH]),
      .alpha(alpha_sel),
      .acc_o(h_o[lane_lsb(k, ACC_WIDTH) +: ACC_WIDTH])
    );
  end

endmodule

// File: tb/tb_aggregator.sv
// Self-checking bench for aggregator against a plain-arithmetic weighted-sum model.
`timescale 1ns/1ps
module tb_aggregator;

  localparam int DW = 8;
  localparam int N  = 5;
  localparam int FW = 8;
  localparam int NF = 4;
  localparam int AW = FW + DW + 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            alpha_valid_i = 1'b0;
  logic            alpha_ready_o;
  logic [N*DW-1:0] alpha_i = '0;
  logic            feat_valid_i = 1'b0;
  logic            feat_ready_o;
  logic [NF*FW-1:0] feat_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [NF*AW-1:0] h_o;

  aggregator #(
    .DATA_WIDTH  (DW),
    .NUM_OF_NODES(N),
    .FEAT_WIDTH  (FW),
    .NUM_OF_FEATS(NF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alpha_valid_i(alpha_valid_i),
    .alpha_ready_o(alpha_ready_o),
    .alpha_i      (alpha_i),
    .feat_valid_i (feat_valid_i),
    .feat_ready_o (feat_ready_o),
    .feat_i       (feat_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .h_o          (h_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int ref_alpha [N];
  int ref_feat  [N][NF];

  // Reference: weighted sum over neighbours in wide integer arithmetic.
  function automatic longint model_lane(input int k);
    longint s;
    s = 0;
    for (int j = 0; j < N; j++) s += longint'(ref_feat[j][k]) * longint'(ref_alpha[j]);
`ifdef AGG_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  function automatic longint dut_lane(input int k);
    logic signed [AW-1:0] v;
    v = h_o[k*AW +: AW];
    return longint'(v);
  endfunction

  function automatic int rand_feat();
    return int'($urandom_range(255, 0)) - 128;
  endfunction

  task automatic fill_uniform(input int a, input int f);
    for (int j = 0; j < N; j++) begin
      ref_alpha[j] = a;
      for (int k = 0; k < NF; k++) ref_feat[j][k] = f;
    end
  endtask

  task automatic fill_random();
    for (int j = 0; j < N; j++) begin
      ref_alpha[j] = int'($urandom_range(255, 0));
      for (int k = 0; k < NF; k++) ref_feat[j][k] = rand_feat();
    end
  endtask

  task automatic load_alpha_bus();
    for (int j = 0; j < N; j++) alpha_i[j*DW +: DW] = DW'(ref_alpha[j]);
  endtask

  task automatic send_alpha(output bit to);
    int  n;
    bit  rdy;
    n  = 0;
    to = 1'b0;
    load_alpha_bus();
    alpha_valid_i = 1'b1;
    while (1) begin
      rdy = alpha_ready_o;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 50) begin to = 1'b1; break; end
    end
    alpha_valid_i = 1'b0;
  endtask

  task automatic send_feat(input int j, input int gap, output bit to);
    int n;
    bit rdy;
    n  = 0;
    to = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    for (int k = 0; k < NF; k++) feat_i[k*FW +: FW] = FW'(ref_feat[j][k]);
    feat_valid_i = 1'b1;
    while (1) begin
      rdy = feat_ready_o;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 50) begin to = 1'b1; break; end
    end
    feat_valid_i = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit to);
    lat = 0;
    while (!out_valid_o && lat < 50) begin @(posedge clk); #1; lat++; end
    to = !out_valid_o;
  endtask

  task automatic run_node(input int gap_lo, input int gap_hi, output bit to, output int lat);
    bit t;
    send_alpha(t);
    to = t;
    for (int j = 0; j < N; j++) begin
      send_feat(j, int'($urandom_range(gap_hi, gap_lo)), t);
      to |= t;
    end
    wait_out(lat, t);
    to |= t;
  endtask

  task automatic take_out();
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({alpha_ready_o, feat_ready_o, out_valid_o} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000", {alpha_ready_o, feat_ready_o, out_valid_o});
    end
    checks++;
    if (h_o !== '0) begin errors++; $display("FAIL reset_h: got %h want 0", h_o); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({alpha_ready_o, feat_ready_o, out_valid_o} !== 3'b100) begin
      errors++; $display("FAIL post_reset_idle: got %b want 100", {alpha_ready_o, feat_ready_o, out_valid_o});
    end
  endtask

  task automatic test_uniform();
    bit to; int lat;
    fill_uniform(51, 10);
    run_node(0, 0, to, lat);
    checks++;
    if (to) begin errors++; $display("FAIL uniform_timeout: got timeout want none"); end
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL uniform_latency: got %0d extra cycles want 0", lat); end
    for (int k = 0; k < NF; k++) begin
      checks++;
      if (dut_lane(k) !== model_lane(k)) begin
        errors++; $display("FAIL uniform_lane%0d: got %0d want %0d", k, dut_lane(k), model_lane(k));
      end
    end
    take_out();
    checks++;
    if ({out_valid_o, alpha_ready_o} !== 2'b01) begin
      errors++; $display("FAIL uniform_release: got %b want 01", {out_valid_o, alpha_ready_o});
    end
  endtask

  task automatic test_slot0();
    bit to; int lat; longint want0;
    fill_random();
    for (int j = 0; j < N; j++) begin
      ref_alpha[j] = (j == 0) ? 255 : 0;
      ref_feat[j][0] = (j == 0) ? -3 : 100;
    end
`ifdef AGG_RELU_EN
    want0 = 0;
`else
    want0 = -765;
`endif
    run_node(0, 0, to, lat);
    checks++;
    if (to) begin errors++; $display("FAIL slot0_timeout: got timeout want none"); end
    checks++;
    if (dut_lane(0) !== want0) begin
      errors++; $display("FAIL slot0_lane0: got %0d want %0d", dut_lane(0), want0);
    end
    for (int k = 1; k < NF; k++) begin
      checks++;
      if (dut_lane(k) !== model_lane(k)) begin
        errors++; $display("FAIL slot0_lane%0d: got %0d want %0d", k, dut_lane(k), model_lane(k));
      end
    end
    take_out();
  endtask

  task automatic test_gaps();
    bit to; int lat;
    logic [NF*AW-1:0] snap;
    fill_uniform(51, 10);
    run_node(1, 3, to, lat);
    checks++;
    if (to || lat !== 0) begin errors++; $display("FAIL gaps_handshake: got to=%0d lat=%0d want to=0 lat=0", to, lat); end
    for (int k = 0; k < NF; k++) begin
      checks++;
      if (dut_lane(k) !== model_lane(k)) begin
        errors++; $display("FAIL gaps_lane%0d: got %0d want %0d", k, dut_lane(k), model_lane(k));
      end
    end
    // Offer feature beats while DONE: they must be refused and not disturb h_o.
    snap = h_o;
    feat_i = NF*FW'($urandom);
    feat_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (feat_ready_o !== 1'b0 || h_o !== snap) begin
        errors++; $display("FAIL gaps_done_feat: got ready=%b h=%h want ready=0 h=%h", feat_ready_o, h_o, snap);
      end
    end
    take_out();
    checks++;
    if (feat_ready_o !== 1'b0) begin errors++; $display("FAIL gaps_idle_feat: got ready=%b want 0", feat_ready_o); end
    feat_valid_i = 1'b0;
  endtask

  task automatic test_backpressure();
    bit to; int lat;
    logic [NF*AW-1:0] snap;
    fill_random();
    run_node(0, 1, to, lat);
    for (int k = 0; k < NF; k++) begin
      checks++;
      if (to || dut_lane(k) !== model_lane(k)) begin
        errors++; $display("FAIL bp_first_lane%0d: got %0d want %0d (to=%0d)", k, dut_lane(k), model_lane(k), to);
      end
    end
    snap = h_o;
    fill_random();
    load_alpha_bus();
    alpha_valid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid_o, alpha_ready_o} !== 2'b10 || h_o !== snap) begin
        errors++; $display("FAIL bp_hold: got vld/rdy=%b h=%h want 10 h=%h", {out_valid_o, alpha_ready_o}, h_o, snap);
      end
    end
    take_out();
    checks++;
    if ({out_valid_o, alpha_ready_o} !== 2'b01) begin
      errors++; $display("FAIL bp_after_out: got %b want 01", {out_valid_o, alpha_ready_o});
    end
    @(posedge clk); #1;
    alpha_valid_i = 1'b0;
    checks++;
    if ({alpha_ready_o, feat_ready_o} !== 2'b01) begin
      errors++; $display("FAIL bp_alpha_taken: got %b want 01", {alpha_ready_o, feat_ready_o});
    end
    for (int j = 0; j < N; j++) begin
      bit t;
      send_feat(j, 0, t);
      to |= t;
    end
    wait_out(lat, to);
    for (int k = 0; k < NF; k++) begin
      checks++;
      if (to || dut_lane(k) !== model_lane(k)) begin
        errors++; $display("FAIL bp_second_lane%0d: got %0d want %0d (to=%0d)", k, dut_lane(k), model_lane(k), to);
      end
    end
    take_out();
  endtask

  task automatic test_abort();
    bit to; int lat; int seen;
    fill_random();
    send_alpha(to);
    send_feat(0, 0, to);
    send_feat(1, 0, to);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    checks++;
    if ({out_valid_o, feat_ready_o} !== 2'b00 || h_o !== '0) begin
      errors++; $display("FAIL abort_reset: got vld/rdy=%b h=%h want 00 h=0", {out_valid_o, feat_ready_o}, h_o);
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid_o) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_output: got %0d valid cycles want 0", seen); end
    fill_uniform(51, 10);
    run_node(0, 0, to, lat);
    for (int k = 0; k < NF; k++) begin
      checks++;
      if (to || dut_lane(k) !== model_lane(k)) begin
        errors++; $display("FAIL abort_next_lane%0d: got %0d want %0d (to=%0d)", k, dut_lane(k), model_lane(k), to);
      end
    end
    take_out();
  endtask

  task automatic test_extremes();
    bit to; int lat;
    fill_uniform(255, -128);
    run_node(0, 0, to, lat);
    for (int k = 0; k < NF; k++) begin
      checks++;
      if (to || dut_lane(k) !== model_lane(k)) begin
        errors++; $display("FAIL extreme_lane%0d: got %0d want %0d (to=%0d)", k, dut_lane(k), model_lane(k), to);
      end
    end
    take_out();
  endtask

  task automatic test_random();
    bit to; int lat;
    for (int n = 0; n < 6; n++) begin
      fill_random();
      run_node(0, 2, to, lat);
      checks++;
      if (to || lat !== 0) begin errors++; $display("FAIL rand%0d_handshake: got to=%0d lat=%0d want 0/0", n, to, lat); end
      for (int k = 0; k < NF; k++) begin
        checks++;
        if (dut_lane(k) !== model_lane(k)) begin
          errors++; $display("FAIL rand%0d_lane%0d: got %0d want %0d", n, k, dut_lane(k), model_lane(k));
        end
      end
      repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
      take_out();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_uniform();
    test_slot0();
    test_gaps();
    test_backpressure();
    test_abort();
    test_extremes();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
